// File: rtl/uart_seq_pkg.sv
// Shared constants for the UART echo sequencer: FSM state codes, status
// register bit positions, default register map and the ASCII case helper.
package uart_seq_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RX_POLL  = 3'd1;
    localparam logic [2:0] ST_RX_READ  = 3'd2;
    localparam logic [2:0] ST_TX_POLL  = 3'd3;
    localparam logic [2:0] ST_TX_WRITE = 3'd4;
    localparam logic [2:0] ST_ERROR    = 3'd5;

    localparam int RX_VALID_BIT = 0;
    localparam int TX_BUSY_BIT  = 1;

    localparam logic [31:0] DEFAULT_ADDR_STATUS = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_ADDR_RXDATA = 32'h0000_0004;
    localparam logic [31:0] DEFAULT_ADDR_TXDATA = 32'h0000_0008;

    localparam logic [7:0] ASCII_LOWER_A    = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z    = 8'h7A;
    localparam logic [7:0] ASCII_CASE_DELTA = 8'h20;

    // Lower-case ASCII letters become upper case only when the switch is on.
    function automatic logic [7:0] upcase_byte(input logic [7:0] b, input logic en);
        if (en && (b >= ASCII_LOWER_A) && (b <= ASCII_LOWER_Z))
            return b - ASCII_CASE_DELTA;
        return b;
    endfunction

endpackage

// File: rtl/uart_seq_bus_master.sv
// Single-outstanding-request bus engine: launches one read or write on start,
// holds it through stalls, reports completion and returns to idle.
module uart_seq_bus_master
    import uart_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        bus_ren,
    output logic        bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_strobe,
    input  logic [31:0] bus_rdata,
    input  logic        bus_stall,
    input  logic        bus_error
);

    logic active;

    // start is ignored while a request is in flight, so the sequencer may keep
    // it asserted through the completing cycle without launching a duplicate.
    always_ff @(posedge clk) begin
        if (reset) begin
            active     <= 1'b0;
            bus_ren    <= 1'b0;
            bus_wen    <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_strobe <= '0;
        end else if (active) begin
            if (!bus_stall) begin
                active     <= 1'b0;
                bus_ren    <= 1'b0;
                bus_wen    <= 1'b0;
                bus_addr   <= '0;
                bus_wdata  <= '0;
                bus_strobe <= '0;
            end
        end else if (start) begin
            active     <= 1'b1;
            bus_ren    <= !is_write;
            bus_wen    <= is_write;
            bus_addr   <= addr;
            bus_wdata  <= is_write ? wdata : 32'h0;
            bus_strobe <= is_write ? 4'b0001 : 4'b0000;
        end
    end

    // A stalled cycle never completes, so an error seen under stall is ignored.
    assign done  = active && !bus_stall;
    assign err   = done && bus_error;
    assign rdata = bus_rdata;

endmodule

// File: rtl/uart_echo_sequencer.sv
// On-board UART echo test: polls the AHBUart status, reads each received byte,
// optionally upper-cases it and writes it back once the transmitter is idle.
module uart_echo_sequencer
    import uart_seq_pkg::*;
#(
    parameter logic [31:0] ADDR_STATUS = DEFAULT_ADDR_STATUS,
    parameter logic [31:0] ADDR_RXDATA = DEFAULT_ADDR_RXDATA,
    parameter logic [31:0] ADDR_TXDATA = DEFAULT_ADDR_TXDATA,
    parameter int          POLL_LIMIT  = 1024,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             upcase,
    output logic             bus_ren,
    output logic             bus_wen,
    output logic [31:0]      bus_addr,
    output logic [31:0]      bus_wdata,
    output logic [3:0]       bus_strobe,
    input  logic [31:0]      bus_rdata,
    input  logic             bus_stall,
    input  logic             bus_error,
    output logic             busy,
    output logic             err_flag,
    output logic [7:0]       last_byte,
    output logic [CNT_W-1:0] echo_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int PCW = $clog2(POLL_LIMIT + 1);
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_LIMIT - 1);

    logic [2:0]     state;
    logic [PCW-1:0] poll_cnt;
    logic [7:0]     held_byte;

    logic        eng_start;
    logic        eng_is_write;
    logic [31:0] eng_addr;
    logic        eng_done;
    logic        eng_err;
    logic [31:0] eng_rdata;
    logic        rdata_unused;

    assign rdata_unused = ^eng_rdata[31:8];

    // Every bus-facing state simply requests its access; the engine serialises.
    always_comb begin
        eng_start    = 1'b0;
        eng_is_write = 1'b0;
        eng_addr     = ADDR_STATUS;
        case (state)
            ST_RX_POLL: begin
                eng_start = 1'b1;
                eng_addr  = ADDR_STATUS;
            end
            ST_RX_READ: begin
                eng_start = 1'b1;
                eng_addr  = ADDR_RXDATA;
            end
            ST_TX_POLL: begin
                eng_start = 1'b1;
                eng_addr  = ADDR_STATUS;
            end
            ST_TX_WRITE: begin
                eng_start    = 1'b1;
                eng_is_write = 1'b1;
                eng_addr     = ADDR_TXDATA;
            end
            default: begin
                eng_start    = 1'b0;
                eng_is_write = 1'b0;
                eng_addr     = ADDR_STATUS;
            end
        endcase
    end

    uart_seq_bus_master u_bus_master (
        .clk        (clk),
        .reset      (reset),
        .start      (eng_start),
        .is_write   (eng_is_write),
        .addr       (eng_addr),
        .wdata      ({24'h0, held_byte}),
        .done       (eng_done),
        .rdata      (eng_rdata),
        .err        (eng_err),
        .bus_ren    (bus_ren),
        .bus_wen    (bus_wen),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_strobe (bus_strobe),
        .bus_rdata  (bus_rdata),
        .bus_stall  (bus_stall),
        .bus_error  (bus_error)
    );

    // A bus error in any completing transfer parks the FSM in ERROR with no
    // counter update; only reset gets it out again.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            poll_cnt   <= '0;
            held_byte  <= '0;
            err_flag   <= 1'b0;
            last_byte  <= '0;
            echo_count <= '0;
            drop_count <= '0;
        end else if (eng_err) begin
            state    <= ST_ERROR;
            err_flag <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable)
                        state <= ST_RX_POLL;
                end
                ST_RX_POLL: begin
                    if (eng_done)
                        state <= eng_rdata[RX_VALID_BIT] ? ST_RX_READ : ST_IDLE;
                end
                ST_RX_READ: begin
                    if (eng_done) begin
                        held_byte <= upcase_byte(eng_rdata[7:0], upcase);
                        poll_cnt  <= '0;
                        state     <= ST_TX_POLL;
                    end
                end
                ST_TX_POLL: begin
                    if (eng_done) begin
                        if (!eng_rdata[TX_BUSY_BIT]) begin
                            state <= ST_TX_WRITE;
                        end else if (poll_cnt == POLL_LAST) begin
                            poll_cnt   <= '0;
                            drop_count <= drop_count + 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                        end
                    end
                end
                ST_TX_WRITE: begin
                    if (eng_done) begin
                        echo_count <= echo_count + 1'b1;
                        last_byte  <= held_byte;
                        state      <= ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    state <= ST_ERROR;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE) && (state != ST_ERROR);

endmodule

// File: tb/tb_uart_echo_sequencer.sv
// Bench for uart_echo_sequencer: a behavioural UART slave plus table-driven and
// randomized echo scenarios checked against a byte-level reference model.
module tb_uart_echo_sequencer;

    localparam int POLL_LIMIT = 4;
    localparam int CNT_W      = 4;
    localparam logic [31:0] A_STATUS = 32'h0;
    localparam logic [31:0] A_RX     = 32'h4;
    localparam logic [31:0] A_TX     = 32'h8;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             upcase;
    logic             bus_ren;
    logic             bus_wen;
    logic [31:0]      bus_addr;
    logic [31:0]      bus_wdata;
    logic [3:0]       bus_strobe;
    logic [31:0]      bus_rdata;
    logic             bus_stall;
    logic             bus_error;
    logic             busy;
    logic             err_flag;
    logic [7:0]       last_byte;
    logic [CNT_W-1:0] echo_count;
    logic [CNT_W-1:0] drop_count;

    uart_echo_sequencer #(
        .POLL_LIMIT (POLL_LIMIT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .upcase     (upcase),
        .bus_ren    (bus_ren),
        .bus_wen    (bus_wen),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_strobe (bus_strobe),
        .bus_rdata  (bus_rdata),
        .bus_stall  (bus_stall),
        .bus_error  (bus_error),
        .busy       (busy),
        .err_flag   (err_flag),
        .last_byte  (last_byte),
        .echo_count (echo_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // slave configuration
    int          stall_n       = 0;
    int          tx_busy_reads = 0;
    bit          rx_pending    = 0;
    logic [7:0]  rx_byte       = 8'h0;
    bit          err_en        = 0;
    logic [31:0] err_addr      = 32'h0;
    bit          stall_err     = 1;

    // slave state and observations
    bit          in_req = 0;
    int          stall_left = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_ren, cap_wen;
    logic [3:0]  cap_strobe;
    int          tx_phase_reads = 0;
    int          n_status_reads = 0;
    int          n_rx_reads = 0;
    int          n_writes = 0;
    int          n_req_cycles = 0;
    int          stab_err = 0;
    int          both_err = 0;
    int          bad_strobe = 0;
    int          bad_addr = 0;
    logic [31:0] last_wdata = 32'h0;
    logic [31:0] last_waddr = 32'h0;
    logic [3:0]  last_wstrobe = 4'h0;

    // Slave responds on the falling edge so the DUT samples settled values.
    always @(negedge clk) begin
        logic [31:0] rnd;
        logic        tx_busy;
        rnd       = $urandom;
        bus_stall = 1'b0;
        bus_error = 1'b0;
        bus_rdata = rnd;
        if (bus_ren === 1'b1 && bus_wen === 1'b1) both_err++;
        if (bus_ren === 1'b1 || bus_wen === 1'b1) begin
            n_req_cycles++;
            if (bus_ren === 1'b1 && bus_strobe !== 4'b0000) bad_strobe++;
            if (!in_req) begin
                in_req     = 1;
                stall_left = stall_n;
                cap_addr   = bus_addr;
                cap_wdata  = bus_wdata;
                cap_ren    = bus_ren;
                cap_wen    = bus_wen;
                cap_strobe = bus_strobe;
            end else if (bus_addr !== cap_addr || bus_wdata !== cap_wdata ||
                         bus_ren !== cap_ren || bus_wen !== cap_wen ||
                         bus_strobe !== cap_strobe) begin
                stab_err++;
            end
            if (stall_left > 0) begin
                stall_left--;
                bus_stall = 1'b1;
                bus_error = stall_err;
            end else begin
                in_req = 0;
                if (bus_wen === 1'b1) begin
                    n_writes++;
                    last_wdata   = bus_wdata;
                    last_waddr   = bus_addr;
                    last_wstrobe = bus_strobe;
                end else if (bus_addr == A_STATUS) begin
                    tx_busy   = (tx_phase_reads < tx_busy_reads);
                    bus_rdata = {rnd[31:2], tx_busy, rx_pending};
                    n_status_reads++;
                    tx_phase_reads++;
                end else if (bus_addr == A_RX) begin
                    bus_rdata      = {rnd[31:8], rx_byte};
                    rx_pending     = 0;
                    tx_phase_reads = 0;
                    n_rx_reads++;
                end else begin
                    bad_addr++;
                end
                if (err_en && bus_addr == err_addr) bus_error = 1'b1;
            end
        end
    end

    typedef struct {
        logic [7:0] rx;
        bit         up;
        int         stall;
        int         busy_reads;
        bit         exp_drop;
        logic [7:0] exp_byte;
        int         exp_polls;
    } vec_t;

    vec_t vecs[11];

    int         exp_echo = 0;
    int         exp_drop = 0;
    logic [7:0] exp_last = 8'h0;

    // Reference: letters a..z shift to A..Z when upcase is on; all else passes.
    function automatic logic [7:0] refEcho(input logic [7:0] b, input bit up);
        if (up && b >= "a" && b <= "z") return b - 8'd32;
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic resetDut();
        reset = 1'b1;
        tick(1);
        in_req     = 0;
        stall_left = 0;
        reset      = 1'b0;
        exp_echo   = 0;
        exp_drop   = 0;
        exp_last   = 8'h0;
    endtask

    // One echo transaction; enable drops as soon as the byte is read so the
    // status reads that follow are exactly the TX polls.
    task automatic applyStimulus(input string name, input logic [7:0] rx, input bit up,
                                 input int stall, input int busy_reads, input bit e_drop,
                                 input logic [7:0] e_byte, input int e_polls);
        int cyc;
        int rx_before;
        int wr_before;
        stall_n       = stall;
        tx_busy_reads = busy_reads;
        rx_byte       = rx;
        upcase        = up;
        rx_before     = n_rx_reads;
        wr_before     = n_writes;
        rx_pending    = 1;
        enable        = 1'b1;
        cyc = 0;
        while (n_rx_reads == rx_before && cyc < 200) begin
            tick(1);
            cyc++;
        end
        checkOutput({name, ".rx_read"}, 32'(n_rx_reads - rx_before), 32'd1);
        enable = 1'b0;
        upcase = ~up;
        cyc = 0;
        while (busy && cyc < 400) begin
            tick(1);
            cyc++;
        end
        tick(2);
        checkOutput({name, ".idle"}, 32'(busy), 32'd0);
        checkOutput({name, ".tx_polls"}, 32'(tx_phase_reads), 32'(e_polls));
        checkOutput({name, ".writes"}, 32'(n_writes - wr_before), e_drop ? 32'd0 : 32'd1);
        if (e_drop) begin
            exp_drop = (exp_drop + 1) % (1 << CNT_W);
        end else begin
            exp_echo = (exp_echo + 1) % (1 << CNT_W);
            exp_last = e_byte;
            checkOutput({name, ".wdata"}, last_wdata, {24'h0, e_byte});
            checkOutput({name, ".waddr"}, last_waddr, A_TX);
            checkOutput({name, ".wstrobe"}, 32'(last_wstrobe), 32'h1);
        end
        checkOutput({name, ".echo_count"}, 32'(echo_count), 32'(exp_echo));
        checkOutput({name, ".drop_count"}, 32'(drop_count), 32'(exp_drop));
        checkOutput({name, ".last_byte"}, 32'(last_byte), 32'(exp_last));
    endtask

    initial begin
        int cyc;
        int req_before;
        logic [7:0] rb;
        bit ru;
        int rs;
        int rbusy;
        bit rdrop;

        vecs[0]  = '{8'h61, 1'b1, 0, 0,   1'b0, 8'h41, 1};
        vecs[1]  = '{8'h7B, 1'b0, 0, 0,   1'b0, 8'h7B, 1};
        vecs[2]  = '{8'h7A, 1'b1, 0, 0,   1'b0, 8'h5A, 1};
        vecs[3]  = '{8'h7B, 1'b1, 0, 0,   1'b0, 8'h7B, 1};
        vecs[4]  = '{8'h60, 1'b1, 0, 0,   1'b0, 8'h60, 1};
        vecs[5]  = '{8'h61, 1'b0, 0, 1,   1'b0, 8'h61, 2};
        vecs[6]  = '{8'h6D, 1'b1, 3, 0,   1'b0, 8'h4D, 1};
        vecs[7]  = '{8'h35, 1'b0, 0, 2,   1'b0, 8'h35, 3};
        vecs[8]  = '{8'h62, 1'b1, 0, 3,   1'b0, 8'h42, 4};
        vecs[9]  = '{8'h63, 1'b1, 0, 4,   1'b1, 8'h00, 4};
        vecs[10] = '{8'h64, 1'b0, 2, 100, 1'b1, 8'h00, 4};

        reset  = 1'b1;
        enable = 1'b0;
        upcase = 1'b0;
        tick(2);
        resetDut();
        checkOutput("rst.ren", 32'(bus_ren), 32'd0);
        checkOutput("rst.wen", 32'(bus_wen), 32'd0);
        checkOutput("rst.addr", bus_addr, 32'd0);
        checkOutput("rst.strobe", 32'(bus_strobe), 32'd0);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.err_flag", 32'(err_flag), 32'd0);
        checkOutput("rst.counts", 32'({echo_count, drop_count, last_byte}), 32'd0);

        $display("[TB] idle polling with no received data");
        enable = 1'b1;
        tick(40);
        checkOutput("idle.status_reads_ge10", 32'(n_status_reads >= 10), 32'd1);
        checkOutput("idle.rx_reads", 32'(n_rx_reads), 32'd0);
        checkOutput("idle.writes", 32'(n_writes), 32'd0);
        checkOutput("idle.echo_count", 32'(echo_count), 32'd0);
        enable = 1'b0;
        cyc = 0;
        while (busy && cyc < 50) begin
            tick(1);
            cyc++;
        end
        tick(2);

        $display("[TB] table vectors");
        foreach (vecs[i])
            applyStimulus($sformatf("vec%0d", i), vecs[i].rx, vecs[i].up, vecs[i].stall,
                          vecs[i].busy_reads, vecs[i].exp_drop, vecs[i].exp_byte,
                          vecs[i].exp_polls);

        $display("[TB] randomized echoes against reference model");
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 1) rb = 8'($urandom_range(8'h5F, 8'h7C));
            else rb = 8'($urandom_range(0, 255));
            ru    = 1'($urandom_range(0, 1));
            rs    = $urandom_range(0, 3);
            rbusy = $urandom_range(0, 5);
            rdrop = (rbusy >= POLL_LIMIT);
            applyStimulus($sformatf("rnd%0d", i), rb, ru, rs, rbusy, rdrop,
                          refEcho(rb, ru), rdrop ? POLL_LIMIT : rbusy + 1);
        end

        $display("[TB] bus error on RX data read");
        stall_n       = 0;
        tx_busy_reads = 0;
        rx_byte       = 8'h71;
        err_addr      = A_RX;
        err_en        = 1;
        rx_pending    = 1;
        enable        = 1'b1;
        cyc = 0;
        while (!err_flag && cyc < 100) begin
            tick(1);
            cyc++;
        end
        tick(1);
        checkOutput("err.flag", 32'(err_flag), 32'd1);
        checkOutput("err.busy", 32'(busy), 32'd0);
        req_before = n_req_cycles;
        rx_pending = 1;
        tick(30);
        checkOutput("err.no_requests", 32'(n_req_cycles - req_before), 32'd0);
        checkOutput("err.echo_count", 32'(echo_count), 32'(exp_echo));
        checkOutput("err.drop_count", 32'(drop_count), 32'(exp_drop));
        err_en     = 0;
        enable     = 1'b0;
        rx_pending = 0;
        resetDut();
        checkOutput("err.reset_flag", 32'(err_flag), 32'd0);
        checkOutput("err.reset_echo", 32'(echo_count), 32'd0);

        $display("[TB] reset in the middle of a stalled transfer");
        stall_n = 20;
        enable  = 1'b1;
        cyc = 0;
        while (bus_ren !== 1'b1 && cyc < 50) begin
            tick(1);
            cyc++;
        end
        tick(2);
        checkOutput("midrst.req_seen", 32'(bus_ren), 32'd1);
        enable  = 1'b0;
        stall_n = 0;
        resetDut();
        checkOutput("midrst.ren", 32'(bus_ren), 32'd0);
        checkOutput("midrst.wen", 32'(bus_wen), 32'd0);
        tick(3);
        checkOutput("midrst.busy", 32'(busy), 32'd0);
        checkOutput("midrst.still_idle", 32'(bus_ren | bus_wen), 32'd0);

        checkOutput("bus.stable_under_stall", 32'(stab_err), 32'd0);
        checkOutput("bus.ren_wen_exclusive", 32'(both_err), 32'd0);
        checkOutput("bus.read_strobe_zero", 32'(bad_strobe), 32'd0);
        checkOutput("bus.known_addresses", 32'(bad_addr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
